// File: rtl/seg7_scan_if.sv
// Bus between the debug-word source and the seven-segment scan driver.
// The master drives the word, load strobe and decimal points. The slave drives the display outputs.
interface seg7_scan_if;
    logic [31:0] data_in;
    logic        load;
    logic [7:0]  dp_in;
    logic [7:0]  AN;
    logic [7:0]  Seg;
    logic        frame_done;

    modport master (output data_in, load, dp_in, input AN, Seg, frame_done);
    modport slave  (input data_in, load, dp_in, output AN, Seg, frame_done);
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit, common-anode seven-segment scanner with frame-synchronous double buffering.
// Define SEG7_LZB_EN to blank the leading zero digits. Digit 0 is always shown.
module seg7_scan #(
    parameter int DIV_BITS = 17
) (
    input  logic       clk,
    input  logic       rst_,
    seg7_scan_if.slave bus
);

    logic [DIV_BITS-1:0] div;
    logic [2:0]          idx;
    logic [31:0]         shadow;
    logic                pending;
    logic [31:0]         disp;

    logic       tick;
    logic       boundary;
    logic [3:0] nibble;
    logic [6:0] glyph;

    assign tick     = &div;
    assign boundary = tick && (idx == 3'd7);
    assign nibble   = disp[{idx, 2'b00} +: 4];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_LZB_EN
    logic [2:0] lead;

    // NOTE: assign every always_comb output before any conditional update, so no latch is inferred.
    always_comb begin
        lead = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (disp[4*i +: 4] != 4'h0) lead = 3'(i);
        end
    end

    assign glyph = (idx > lead) ? 7'h7F : hex7(nibble);
`else
    assign glyph = hex7(nibble);
`endif

    // NOTE: use non-blocking assignments for all sequential state. Every register then samples pre-edge values.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            div <= '0;
            idx <= 3'd0;
        end else begin
            div <= div + 1'b1;
            if (tick) idx <= idx + 3'd1;
        end
    end

    // A load that lands on the boundary commits the older shadow. The new word stays pending.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            shadow  <= '0;
            pending <= 1'b0;
            disp    <= '0;
        end else begin
            if (boundary && pending) disp <= shadow;
            if (bus.load) begin
                shadow  <= bus.data_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            bus.AN         <= 8'hFE;
            bus.Seg        <= 8'hC0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.AN         <= ~(8'b1 << idx);
            bus.Seg        <= {~bus.dp_in[idx], glyph};
            bus.frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DIV_BITS=2. Expected outputs come from a
// cycle-count reference model: digit = (cycle/4)%8, and a commit happens at every 32nd cycle.
module tb_seg7_scan;

    localparam int DWELL = 4;
    localparam int FRAME = 8 * DWELL;

    logic clk = 1'b0;
    logic rst_;

    seg7_scan_if bus ();

    seg7_scan #(.DIV_BITS(2)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_cyc;
    logic [31:0] m_shadow, m_disp;
    logic        m_pend;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [31:0] w, input int d);
        int k;
        k = 0;
`ifdef SEG7_LZB_EN
        for (int j = 0; j < 8; j++) if (((w >> (4*j)) & 32'hF) != 0) k = j;
        if (d > k) return 7'h7F;
`endif
        return hex_tab[(w >> (4*d)) & 32'hF][6:0];
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        m_shadow = '0;
        m_disp = '0;
        m_pend = 1'b0;
    endtask

    // Drive one cycle from just after a falling edge, then check outputs after the rising edge.
    task automatic step(input logic [31:0] d, input logic ld, input logic [7:0] dp);
        int          digit;
        logic [7:0]  exp_an, exp_seg;
        logic        exp_fd;
        bus.data_in = d;
        bus.load    = ld;
        bus.dp_in   = dp;
        digit   = (m_cyc / DWELL) % 8;
        exp_an  = ~(8'd1 << digit);
        exp_seg = {~dp[digit], ref_glyph(m_disp, digit)};
        exp_fd  = ((m_cyc % FRAME) == FRAME - 1);
        if (exp_fd && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end
        m_cyc++;
        @(posedge clk);
        #1;
        chk("AN", 32'(bus.AN), 32'(exp_an));
        chk("Seg", 32'(bus.Seg), 32'(exp_seg));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [7:0] dp);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, dp);
    endtask

    task automatic idle_to(input int phase);
        while ((m_cyc % FRAME) != phase) step(32'h0, 1'b0, 8'h00);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_AN"}, 32'(bus.AN), 32'h0000_00FE);
        chk({tag, "_Seg"}, 32'(bus.Seg), 32'h0000_00C0);
        chk({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
    endtask

    initial begin
        bus.data_in = '0;
        bus.load    = 1'b0;
        bus.dp_in   = '0;
        rst_        = 1'b1;
        model_reset();

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("reset");
        end
        @(negedge clk);
        rst_ = 1'b0;

        // First frame: load 0123_89AB, then let it commit and scan a full frame
        step(32'h0123_89AB, 1'b1, 8'h00);
        idle(2 * FRAME + 6, 8'h00);

        // Two loads in one frame: only the second one may be shown
        idle_to(2);
        step(32'h1111_1111, 1'b1, 8'h00);
        idle(5, 8'h00);
        step(32'h2222_2222, 1'b1, 8'h00);
        idle(2 * FRAME, 8'h00);

        // Load exactly on the boundary cycle with nothing pending
        idle_to(FRAME - 1);
        step(32'hFFFF_FFFF, 1'b1, 8'h00);
        idle(2 * FRAME + 4, 8'h00);

        // Reset mid-frame at digit 5 with a load pending
        idle_to(1);
        step(32'hAABB_CCDD, 1'b1, 8'h00);
        idle_to(5 * DWELL + 1);
        rst_ = 1'b1;
        #1;
        chk_reset_outputs("midrst_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst_next");
        @(negedge clk);
        rst_ = 1'b0;
        model_reset();

        // Decimal point on digit 0 with disp still zero, across the next boundary
        idle(2 * FRAME + 2, 8'h01);

        // Randomized loads and decimal points
        for (int i = 0; i < 600; i++) begin
            logic ld;
            ld = ($urandom_range(0, 7) == 0);
            step($urandom, ld, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the board's eight-digit, common-anode seven-segment display, downstream of the CPU top. It consumes the 32-bit debug word (imm, pc or ir, selected upstream by the switches) and shows it as eight hex digits. Digits are scanned one at a time. New values are double-buffered and committed only at frame boundaries, so the display never tears mid-scan.

## Interface
Parameters:
- DIV_BITS, 17: digit dwell is 2^DIV_BITS clk cycles. Benches override it to 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_  in  1  asynchronous, active-high reset.
- data_in  in  32  word to display; nibble i goes to digit i.
- load  in  1  capture data_in into the shadow register this cycle.
- dp_in  in  8  decimal-point enables, one per digit, active-high; not buffered.
- AN  out  8  digit anodes, active-low, one-hot-low.
- Seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- State:
  - div: DIV_BITS-bit free-running counter.
  - idx: 3-bit digit index.
  - shadow[31:0] and pending: the buffer stage.
  - disp[31:0]: the committed value being shown.
  - AN, Seg, frame_done: output registers.
- tick = (div == all-ones). div wraps to 0 after all-ones.
- On tick: idx <= idx+1, wrapping 7 -> 0.
- Frame boundary = tick && idx==7. On the boundary:
  - frame_done <= 1; frame_done is 0 on all other cycles.
  - If pending: disp <= shadow and pending <= 0.
- load: shadow <= data_in and pending <= 1. If several loads occur in one frame, the last one wins.
- load coinciding with a boundary:
  - disp takes the old shadow (and only if pending was already 1).
  - shadow takes the new data_in.
  - pending stays or becomes 1.
- Outputs, registered every cycle from the current idx, disp and dp_in:
  - AN <= ~(8'b1 << idx).
  - Seg[6:0] <= hex pattern of disp[4*idx+3:4*idx].
  - Seg[7] <= ~dp_in[idx].
- Hex patterns (active-low, dp bit shown as 1):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- Reset values:
  - div=0, idx=0, shadow=0, pending=0, disp=0.
  - AN=8'hFE, Seg=8'hC0, frame_done=0.
- Reset asserted mid-frame: all state returns to the reset values immediately. Any pending load is discarded.

## Timing
- idx changes on the edge after a tick. AN/Seg follow one edge later, so the outputs lag idx by one cycle. Each digit is lit for exactly 2^DIV_BITS cycles.
- Frame length is 8 * 2^DIV_BITS cycles. frame_done is asserted during the first cycle in which idx==0 (i.e. the cycle following the boundary edge).
- Latency from load to display:
  - The value reaches disp at the next boundary edge.
  - It first appears on Seg/AN one cycle after that edge, as digit 0.
  - Worst case is 8 * 2^DIV_BITS + 1 cycles.
- dp_in is not buffered. It appears one cycle after it is sampled.

## Configuration
- SEG7_LZB_EN defined (leading-zero blanking):
  - Let k be the index of the most significant nonzero nibble of disp, with k=0 if disp==0.
  - For idx > k, Seg[6:0] <= 7'h7F (blank).
  - AN scanning and Seg[7] are unchanged.
  - Digit 0 is always shown.
- SEG7_LZB_EN undefined: all eight digits always show their hex pattern, including leading zeros.

## Test plan
All scenarios use DIV_BITS=2 (4-cycle dwell, 32-cycle frame).
- Reset: hold rst_ for 3 cycles, then release -> AN=FE, Seg=C0, frame_done=0. The first frame_done pulse occurs on cycle 32 after release.
- Load 32'h0123_89AB, then wait for a boundary -> the digit 0..7 sequence shows Seg = 83, 88, 90, 80, B0, A4, F9, C0. With SEG7_LZB_EN, digit 7 shows FF instead.
- Two loads in one frame (32'h1111_1111, then 32'h2222_2222) -> the next frame shows all digits A4; 1 (F9) never appears.
- Load 32'hFFFF_FFFF on the boundary cycle with pending=0 -> the following frame still shows the old value. The frame after that shows 8E on all digits.
- dp_in=8'h01 with disp=0 -> digit 0 Seg=40 and all other digits Seg=C0. AN walks FE, FD, FB, …, 7F, holding each value for 4 cycles.
- Assert rst_ mid-frame with idx=5 and pending=1 -> on the next cycle AN=FE and Seg=C0. After release, disp stays 0 through the next boundary.
